// File: rtl/axi_line_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_line_master_if
// Description : AXI4 write (AW/W/B) and read (AR/R) channel bundle between the
//               cache line master and the external memory port.
//               master modport : drives aw*, w*, ar*, bready, rready
//               slave modport  : drives awready, wready, b*, arready, r*
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_line_master_if #(
    parameter int ADDR_SIZE  = 32,
    parameter int DATA_WIDTH = 32
);
    // write address channel
    logic [ADDR_SIZE-1:0]    awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    // write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // write response channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // read address channel
    logic [ADDR_SIZE-1:0]    araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    // read data channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_line_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_line_master
// Description : Moves one cache line between the cache data array and memory
//               as a single AXI4 INCR burst: AW/W/B for a write-back, AR/R for
//               a fill. Pulses done (with err) when the burst completes.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req_valid/ready   - request handshake from cache controller
//               req_write         - 1 = write-back, 0 = fill
//               req_addr          - line address (offset bits ignored)
//               done, err         - completion pulse and sticky error status
//               line_beat         - data-array word index for current beat
//               line_rdata        - data-array word for write-back beats
//               fill_we/line_wdata- data-array write for fill beats
//               bus               - AXI4 master channels
// Revision    : 1.0 - initial release
// ============================================================================
module axi_line_master #(
    parameter int ADDR_SIZE  = 32,
    parameter int BLOCK_SIZE = 6,
    parameter int DATA_WIDTH = 32
) (
    input  wire                                                     clk,
    input  wire                                                     rst,
    input  wire                                                     req_valid,
    output logic                                                    req_ready,
    input  wire                                                     req_write,
    input  wire  [ADDR_SIZE-1:0]                                    req_addr,
    output logic                                                    done,
    output logic                                                    err,
    output logic [$clog2((2**BLOCK_SIZE)/(DATA_WIDTH/8))-1:0]       line_beat,
    input  wire  [DATA_WIDTH-1:0]                                   line_rdata,
    output logic                                                    fill_we,
    output logic [DATA_WIDTH-1:0]                                   line_wdata,
    axi_line_master_if.master                                       bus
);

    localparam int c_BEATS = (2**BLOCK_SIZE) / (DATA_WIDTH/8);
    localparam int c_CNT_W = $clog2(c_BEATS);

    localparam logic [c_CNT_W-1:0] c_LAST_BEAT  = c_CNT_W'(c_BEATS-1);
    localparam logic [7:0]         c_LEN        = 8'(c_BEATS-1);
    localparam logic [2:0]         c_SIZE       = 3'($clog2(DATA_WIDTH/8));
    localparam logic [1:0]         c_BURST_INCR = 2'b01;

    typedef logic [2:0] state_t;
    localparam state_t c_S_IDLE = 3'd0;
    localparam state_t c_S_AW   = 3'd1;
    localparam state_t c_S_W    = 3'd2;
    localparam state_t c_S_B    = 3'd3;
    localparam state_t c_S_AR   = 3'd4;
    localparam state_t c_S_R    = 3'd5;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [ADDR_SIZE-1:0]   w_addr_nxt;
    logic                   r_err;
    logic                   w_err_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_last_beat;

    // Line-offset address bits and the low response bits carry no information here.
    logic w_unused;
    assign w_unused = ^{req_addr[BLOCK_SIZE-1:0], bus.bresp[0], bus.rresp[0]};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;
        w_last_beat = (r_cnt == c_LAST_BEAT);

        req_ready   = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.bready  = 1'b0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        fill_we     = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_addr_nxt  = {req_addr[ADDR_SIZE-1:BLOCK_SIZE], {BLOCK_SIZE{1'b0}}};
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = req_write ? c_S_AW : c_S_AR;
                end
            end

            c_S_AW: begin
                bus.awvalid = 1'b1;
                if (bus.awready) begin
                    w_state_nxt = c_S_W;
                end
            end

            c_S_W: begin
                // wdata comes straight from the data array at line_beat=r_cnt,
                // so it stays stable for as long as r_cnt is held.
                bus.wvalid = 1'b1;
                bus.wlast  = w_last_beat;
                if (bus.wready) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last_beat) begin
                        w_state_nxt = c_S_B;
                    end
                end
            end

            c_S_B: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    w_err_nxt   = r_err | bus.bresp[1];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            end

            c_S_AR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    w_state_nxt = c_S_R;
                end
            end

            c_S_R: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    fill_we = 1'b1;
                    // rlast must coincide with the final counted beat; early or
                    // missing rlast both flag an error, the beat count is authoritative.
                    w_err_nxt = r_err | bus.rresp[1] | (bus.rlast ^ w_last_beat);
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last_beat) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Static burst fields and datapath
    // ------------------------------------------------------------------------
    assign bus.awaddr  = r_addr;
    assign bus.awlen   = c_LEN;
    assign bus.awsize  = c_SIZE;
    assign bus.awburst = c_BURST_INCR;
    assign bus.wdata   = line_rdata;
    assign bus.wstrb   = '1;
    assign bus.araddr  = r_addr;
    assign bus.arlen   = c_LEN;
    assign bus.arsize  = c_SIZE;
    assign bus.arburst = c_BURST_INCR;

    assign line_beat   = r_cnt;
    assign line_wdata  = bus.rdata;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_line_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_line_master
// Description : Self-checking bench for axi_line_master. A cycle-stepped AXI
//               slave model drives the memory side; expected addresses and
//               write data are queued when a request is issued and consumed as
//               the DUT produces the matching bus beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_line_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        done;
    logic        err;
    logic [3:0]  line_beat;
    logic [31:0] line_rdata;
    logic        fill_we;
    logic [31:0] line_wdata;

    logic [31:0] mem_line [16];

    int n_chk;
    int n_err;

    logic [31:0] addr_q  [$];
    logic [31:0] wdata_q [$];
    logic [31:0] fill_q  [$];

    axi_line_master_if #(.ADDR_SIZE(32), .DATA_WIDTH(32)) bus ();

    axi_line_master #(
        .ADDR_SIZE  (32),
        .BLOCK_SIZE (6),
        .DATA_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .done       (done),
        .err        (err),
        .line_beat  (line_beat),
        .line_rdata (line_rdata),
        .fill_we    (fill_we),
        .line_wdata (line_wdata),
        .bus        (bus)
    );

    assign line_rdata = mem_line[line_beat];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
    endtask

    // One line transfer. rerr_beat / abort_beat < 0 disable that fault.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input bit wtog,
                           input logic [1:0] bresp_k, input int rerr_beat,
                           input bit drop_last, input int abort_beat);
        int          beat;
        int          aw_wait;
        bit          fin;
        bit          done_due;
        bit          exp_err;
        bit          tog;
        bit          aw_done;
        bit          prev_wstall;
        bit          abort;
        logic [31:0] prev_wdata;
        logic        prev_wlast;
        logic [31:0] e;

        beat = 0; aw_wait = 0; fin = 0; done_due = 0; tog = 1; aw_done = 0;
        prev_wstall = 0; prev_wdata = '0; prev_wlast = 1'b0; abort = 0;

        addr_q.push_back({addr[31:6], 6'b0});
        for (int i = 0; i < 16; i++) begin
            mem_line[i] = $urandom;
            if (wr) wdata_q.push_back(mem_line[i]);
        end
        if (wr) exp_err = bresp_k[1];
        else    exp_err = (rerr_beat >= 0 && rerr_beat < 16) || drop_last;

        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        #1 chk("req_ready_idle", req_ready, 1);
        @(posedge clk);

        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            slave_idle();
            if (cyc == 0) begin
                if (wr) chk("awvalid_latency", bus.awvalid, 1);
                else    chk("arvalid_latency", bus.arvalid, 1);
                chk("req_ready_busy", req_ready, 0);
            end
            if (done_due) begin
                #1;
                chk("done", done, 1);
                chk("err", err, exp_err);
                chk("beats", beat, 16);
                fin = 1;
            end else begin
                bus.awready = bus.awvalid && (aw_wait >= 1);
                if (bus.awvalid) aw_wait++;
                bus.wready  = wtog ? tog : 1'b1;
                if (bus.wvalid) tog = ~tog;
                bus.bvalid  = bus.bready;
                bus.bresp   = bresp_k;
                bus.arready = bus.arvalid;
                bus.rvalid  = bus.rready;
                bus.rdata   = $urandom;
                bus.rresp   = (beat == rerr_beat) ? 2'b11 : 2'b00;
                bus.rlast   = (beat == 15) && !drop_last;
                if (bus.rvalid) fill_q.push_back(bus.rdata);

                abort = (abort_beat >= 0) && bus.wvalid && (beat == abort_beat);
                if (abort) begin
                    bus.wready = 1'b0;
                    rst = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                    slave_idle();
                    #1;
                    chk("rst_wvalid", bus.wvalid, 0);
                    chk("rst_awvalid", bus.awvalid, 0);
                    chk("rst_req_ready", req_ready, 1);
                    chk("rst_done", done, 0);
                    chk("rst_line_beat", line_beat, 0);
                    rst = 1'b0;
                    wdata_q.delete();
                    fin = 1;
                end else begin
                    #1;
                    chk("no_early_done", done, 0);
                    chk("aw_w_overlap", bus.awvalid & bus.wvalid, 0);
                    if (bus.awvalid) begin
                        if (addr_q.size() == 0) chk("awaddr_q_empty", 1, 0);
                        else chk("awaddr", bus.awaddr, addr_q[0]);
                        if (bus.awready) begin
                            chk("awlen", bus.awlen, 15);
                            chk("awsize", bus.awsize, 2);
                            chk("awburst", bus.awburst, 1);
                            if (addr_q.size() != 0) e = addr_q.pop_front();
                            aw_done = 1;
                        end
                    end
                    if (bus.arvalid && bus.arready) begin
                        if (addr_q.size() == 0) chk("araddr_q_empty", 1, 0);
                        else begin
                            e = addr_q.pop_front();
                            chk("araddr", bus.araddr, e);
                        end
                        chk("arlen", bus.arlen, 15);
                        chk("arsize", bus.arsize, 2);
                        chk("arburst", bus.arburst, 1);
                    end
                    if (bus.wvalid) begin
                        chk("w_before_aw", aw_done, 1);
                        if (prev_wstall) begin
                            chk("wdata_hold", bus.wdata, prev_wdata);
                            chk("wlast_hold", bus.wlast, prev_wlast);
                        end
                        chk("wlast", bus.wlast, beat == 15);
                        chk("w_line_beat", line_beat, beat);
                        if (bus.wready) begin
                            chk("wstrb", bus.wstrb, 4'hF);
                            if (wdata_q.size() == 0) chk("wdata_q_empty", 1, 0);
                            else begin
                                e = wdata_q.pop_front();
                                chk("wdata", bus.wdata, e);
                            end
                            beat++;
                        end
                        prev_wstall = !bus.wready;
                        prev_wdata  = bus.wdata;
                        prev_wlast  = bus.wlast;
                    end
                    if (bus.bvalid && bus.bready) done_due = 1;
                    chk("fill_we", fill_we, bus.rvalid && bus.rready);
                    if (bus.rvalid && bus.rready) begin
                        chk("fill_beat", line_beat, beat);
                        if (fill_q.size() == 0) chk("fill_q_empty", 1, 0);
                        else begin
                            e = fill_q.pop_front();
                            chk("fill_data", line_wdata, e);
                        end
                        if (beat == 15) done_due = 1;
                        beat++;
                    end
                end
            end
        end
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk);
        slave_idle();
        #1 chk("done_one_cycle", done, 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        for (int i = 0; i < 16; i++) mem_line[i] = '0;
        slave_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_awvalid", bus.awvalid, 0);
        chk("reset_wvalid", bus.wvalid, 0);
        chk("reset_arvalid", bus.arvalid, 0);
        chk("reset_bready", bus.bready, 0);
        chk("reset_rready", bus.rready, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_fill_we", fill_we, 0);
        chk("reset_line_beat", line_beat, 0);
        rst = 1'b0;

        // fill, zero-wait slave
        run_txn(1'b0, 32'h1234_5678, 1'b0, 2'b00, -1, 1'b0, -1);
        // write-back, wready toggling
        run_txn(1'b1, 32'hABCD_EF3C, 1'b1, 2'b00, -1, 1'b0, -1);
        // write-back, SLVERR response
        run_txn(1'b1, 32'h0000_1FC0, 1'b0, 2'b10, -1, 1'b0, -1);
        // fill, error response on beat 7
        run_txn(1'b0, 32'h8000_0004, 1'b0, 2'b00, 7, 1'b0, -1);
        // fill, rlast missing on final beat
        run_txn(1'b0, 32'h4444_4444, 1'b0, 2'b00, -1, 1'b1, -1);
        // write-back reset during beat 5
        run_txn(1'b1, 32'h7654_3210, 1'b0, 2'b00, -1, 1'b0, 5);
        // fill after reset completes normally
        run_txn(1'b0, 32'hFFFF_FFFF, 1'b0, 2'b00, -1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
